// File: rtl/mdio_phy_poller_if.sv
// AXI-Lite bundle between the PHY poller (master) and the MDIO master (slave).
// Parameters: ADDR_W address width, DATA_W data width (strobes are DATA_W/8).
// Modports: Master drives AW/W/AR channels plus bready/rready; Slave is the mirror.
interface axi_lite_interface #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 16
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport Master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport Slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/mdio_phy_poller.sv
// PHY link poller: optional one-shot configuration write after reset, then a
// periodic read of a PHY status register through an AXI-Lite MDIO master.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   enable             polling permitted; 0 = finish current transaction, then idle
//   poll_now           one-cycle request to read immediately while waiting
//   clear_errors       clears the sticky error flags
//   link_up            last sampled link bit
//   link_changed       one-cycle pulse when link_up toggles
//   status_data        last successfully read register value
//   status_valid       one-cycle pulse per successful read
//   busy               high while an AXI transaction is in progress
//   timeout_error      sticky, a transaction exceeded TIMEOUT_CLKS
//   bus_error          sticky, a non-OKAY response was received
//   mdio_axil          AXI-Lite master port (5-bit address, 16-bit data)
module mdio_phy_poller #(
   parameter int unsigned POLL_INTERVAL_CLKS = 1_000_000,
   parameter logic [4:0]  STATUS_REG_ADDRESS = 5'h01,
   parameter int unsigned LINK_BIT           = 2,
   parameter bit          INIT_ENABLE        = 1'b1,
   parameter logic [4:0]  INIT_REG_ADDRESS   = 5'h18,
   parameter logic [15:0] INIT_REG_DATA      = 16'h0000,
   parameter int unsigned TIMEOUT_CLKS       = 65536
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        poll_now,
   input  logic        clear_errors,
   output logic        link_up,
   output logic        link_changed,
   output logic [15:0] status_data,
   output logic        status_valid,
   output logic        busy,
   output logic        timeout_error,
   output logic        bus_error,
   axi_lite_interface.Master mdio_axil
);
   localparam int unsigned CNT_W = 32;

   typedef enum logic [2:0] {IDLE, INIT_W, INIT_B, RD_AR, RD_R, WAIT} state_t;

   state_t            state;
   logic              init_done;
   logic [CNT_W-1:0]  poll_cnt;
   logic [CNT_W-1:0]  tmo_cnt;
   logic              awvalid, wvalid, bready, arvalid, rready;
   logic [4:0]        awaddr, araddr;
   logic [15:0]       wdata;

   assign mdio_axil.awaddr  = awaddr;
   assign mdio_axil.awprot  = 3'b000;
   assign mdio_axil.awvalid = awvalid;
   assign mdio_axil.wdata   = wdata;
   assign mdio_axil.wstrb   = 2'b11;
   assign mdio_axil.wvalid  = wvalid;
   assign mdio_axil.bready  = bready;
   assign mdio_axil.araddr  = araddr;
   assign mdio_axil.arprot  = 3'b000;
   assign mdio_axil.arvalid = arvalid;
   assign mdio_axil.rready  = rready;

   // Channel handshakes
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, tmo_hit;
   assign aw_hs = awvalid & mdio_axil.awready;
   assign w_hs  = wvalid  & mdio_axil.wready;
   assign b_hs  = bready  & mdio_axil.bvalid;
   assign ar_hs = arvalid & mdio_axil.arready;
   assign r_hs  = rready  & mdio_axil.rvalid;

   // Timeout fires once, on the TIMEOUT_CLKS-th busy cycle that does not complete the transaction
   assign tmo_hit = busy && (tmo_cnt == CNT_W'(TIMEOUT_CLKS - 1)) && !b_hs && !r_hs;

   // Sequencer, channel drivers and status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         init_done     <= 1'b0;
         poll_cnt      <= '0;
         tmo_cnt       <= '0;
         awvalid       <= 1'b0;
         wvalid        <= 1'b0;
         bready        <= 1'b0;
         arvalid       <= 1'b0;
         rready        <= 1'b0;
         awaddr        <= '0;
         araddr        <= '0;
         wdata         <= '0;
         link_up       <= 1'b0;
         link_changed  <= 1'b0;
         status_data   <= '0;
         status_valid  <= 1'b0;
         busy          <= 1'b0;
         timeout_error <= 1'b0;
         bus_error     <= 1'b0;
      end else begin
         status_valid <= 1'b0;
         link_changed <= 1'b0;

         // Saturating transaction age; cleared when a new transaction starts below
         if (busy && tmo_cnt != CNT_W'(TIMEOUT_CLKS)) tmo_cnt <= tmo_cnt + CNT_W'(1);

         // Clear first so a same-cycle error event wins
         if (clear_errors) begin
            timeout_error <= 1'b0;
            bus_error     <= 1'b0;
         end
         if (tmo_hit) timeout_error <= 1'b1;

         case (state)
            IDLE: begin
               if (enable) begin
                  busy    <= 1'b1;
                  tmo_cnt <= '0;
                  if (INIT_ENABLE && !init_done) begin
                     state   <= INIT_W;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     awaddr  <= INIT_REG_ADDRESS;
                     wdata   <= INIT_REG_DATA;
                  end else begin
                     state   <= RD_AR;
                     arvalid <= 1'b1;
                     araddr  <= STATUS_REG_ADDRESS;
                  end
               end
            end
            INIT_W: begin
               if (aw_hs) awvalid <= 1'b0;
               if (w_hs)  wvalid  <= 1'b0;
               if ((aw_hs || !awvalid) && (w_hs || !wvalid)) begin
                  state  <= INIT_B;
                  bready <= 1'b1;
               end
            end
            INIT_B: begin
               if (b_hs) begin
                  bready    <= 1'b0;
                  init_done <= 1'b1;
                  if (mdio_axil.bresp != 2'b00) bus_error <= 1'b1;
                  if (enable) begin
                     state   <= RD_AR;
                     arvalid <= 1'b1;
                     araddr  <= STATUS_REG_ADDRESS;
                     tmo_cnt <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            RD_AR: begin
               if (ar_hs) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= RD_R;
               end
            end
            RD_R: begin
               if (r_hs) begin
                  rready <= 1'b0;
                  busy   <= 1'b0;
                  if (mdio_axil.rresp == 2'b00) begin
                     status_data  <= mdio_axil.rdata;
                     status_valid <= 1'b1;
                     link_up      <= mdio_axil.rdata[LINK_BIT];
                     link_changed <= mdio_axil.rdata[LINK_BIT] ^ link_up;
                  end else begin
                     bus_error <= 1'b1;
                  end
                  if (enable) begin
                     state    <= WAIT;
                     poll_cnt <= CNT_W'(POLL_INTERVAL_CLKS - 1);
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            WAIT: begin
               if (!enable) begin
                  state <= IDLE;
               end else if (poll_cnt == '0 || poll_now) begin
                  state   <= RD_AR;
                  arvalid <= 1'b1;
                  araddr  <= STATUS_REG_ADDRESS;
                  tmo_cnt <= '0;
                  busy    <= 1'b1;
               end else begin
                  poll_cnt <= poll_cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mdio_phy_poller.sv
// Testbench for mdio_phy_poller: AXI-Lite responder model, a table of read
// responses with expected outputs, and directed sequences for init, poll
// interval, poll_now, enable cycling, timeout, bus error and async reset.
module tb_mdio_phy_poller;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable, poll_now, clear_errors;
   logic        link_up, link_changed, status_valid, busy, timeout_error, bus_error;
   logic [15:0] status_data;

   axi_lite_interface #(.ADDR_W(5), .DATA_W(16)) axil ();

   mdio_phy_poller #(
      .POLL_INTERVAL_CLKS(100),
      .STATUS_REG_ADDRESS(5'h01),
      .LINK_BIT(2),
      .INIT_ENABLE(1'b1),
      .INIT_REG_ADDRESS(5'h18),
      .INIT_REG_DATA(16'h1234),
      .TIMEOUT_CLKS(16)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .poll_now(poll_now),
      .clear_errors(clear_errors), .link_up(link_up), .link_changed(link_changed),
      .status_data(status_data), .status_valid(status_valid), .busy(busy),
      .timeout_error(timeout_error), .bus_error(bus_error), .mdio_axil(axil)
   );

   always #5 clk = ~clk;

   // Responder configuration and observation
   logic [15:0] rsp_data;
   logic [1:0]  rsp_resp;
   int          rd_delay;
   int          wr_count = 0, rd_count = 0, ar_count = 0, ar_at_wr = -1;
   logic [4:0]  wr_addr, last_araddr;
   logic [15:0] wr_data;
   logic        aw_got, w_got, r_pend;
   int          r_cnt;

   // AXI-Lite slave model
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         axil.bvalid <= 1'b0; axil.bresp <= 2'b00;
         axil.rvalid <= 1'b0; axil.rresp <= 2'b00; axil.rdata <= '0;
         aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0; r_cnt <= 0;
      end else begin
         if (axil.awvalid && axil.awready) begin aw_got <= 1'b1; wr_addr <= axil.awaddr; end
         if (axil.wvalid && axil.wready) begin w_got <= 1'b1; wr_data <= axil.wdata; end
         if (axil.bvalid && axil.bready) begin
            axil.bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
         end else if (aw_got && w_got && !axil.bvalid) begin
            axil.bvalid <= 1'b1; axil.bresp <= 2'b00;
            wr_count <= wr_count + 1; ar_at_wr <= ar_count;
         end
         if (axil.arvalid && axil.arready) begin
            r_pend <= 1'b1; r_cnt <= rd_delay;
            ar_count <= ar_count + 1; last_araddr <= axil.araddr;
         end
         if (axil.rvalid && axil.rready) begin
            axil.rvalid <= 1'b0; r_pend <= 1'b0; rd_count <= rd_count + 1;
         end else if (r_pend && !axil.rvalid) begin
            if (r_cnt == 0) begin
               axil.rvalid <= 1'b1; axil.rdata <= rsp_data; axil.rresp <= rsp_resp;
            end else begin
               r_cnt <= r_cnt - 1;
            end
         end
      end
   end

   int n_tests = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Returns on the negedge right after the next R handshake
   task automatic wait_read(input string name);
      int start;
      start = rd_count;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (rd_count != start) break;
      end
      check({name, "_read_seen"}, 32'(rd_count != start), 32'd1);
   endtask

   task automatic pulse_poll();
      poll_now = 1'b1;
      tick();
      poll_now = 1'b0;
   endtask

   typedef struct {
      logic [15:0] rdata;
      logic [1:0]  rresp;
      logic        sv;
      logic [15:0] data;
      logic        link;
      logic        chg;
      logic        berr;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int n;
      int arc;
      // rdata, rresp | status_valid, status_data, link_up, link_changed, bus_error
      tbl[0] = '{16'h0004, 2'b00, 1'b1, 16'h0004, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{16'h0000, 2'b00, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{16'hFFFB, 2'b00, 1'b1, 16'hFFFB, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{16'h0004, 2'b10, 1'b0, 16'hFFFB, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{16'h00A4, 2'b00, 1'b1, 16'h00A4, 1'b1, 1'b1, 1'b1};
      tbl[5] = '{16'hAAA5, 2'b00, 1'b1, 16'hAAA5, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{16'h1234, 2'b11, 1'b0, 16'hAAA5, 1'b1, 1'b0, 1'b1};

      reset_n = 1'b0; enable = 1'b0; poll_now = 1'b0; clear_errors = 1'b0;
      rsp_data = 16'h0000; rsp_resp = 2'b00; rd_delay = 2;
      axil.awready = 1'b1; axil.wready = 1'b1; axil.arready = 1'b1;
      repeat (3) tick();

      // Reset state
      check("rst_link_up", 32'(link_up), 0);
      check("rst_status_data", 32'(status_data), 0);
      check("rst_status_valid", 32'(status_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_errors", 32'({timeout_error, bus_error, link_changed}), 0);
      check("rst_valids", 32'({axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready}), 0);
      check("rst_wstrb", 32'(axil.wstrb), 32'h3);
      check("rst_addr", 32'({axil.awaddr, axil.araddr}), 0);
      reset_n = 1'b1;
      repeat (3) tick();
      check("idle_no_enable", 32'(busy), 0);

      // Init write then first read
      enable = 1'b1;
      wait_read("first");
      check("init_wr_count", 32'(wr_count), 1);
      check("init_wr_addr", 32'(wr_addr), 32'h18);
      check("init_wr_data", 32'(wr_data), 32'h1234);
      check("init_before_read", 32'(ar_at_wr), 0);
      check("first_araddr", 32'(last_araddr), 32'h01);
      check("first_sv", 32'(status_valid), 1);
      check("first_link", 32'(link_up), 0);
      check("first_no_change", 32'(link_changed), 0);

      // poll_now well before the interval expires; poll_now outside WAIT ignored
      repeat (10) tick();
      pulse_poll();
      check("poll_now_arvalid", 32'(axil.arvalid), 1);
      tick();
      poll_now = 1'b1;
      tick();
      poll_now = 1'b0;
      wait_read("pollnow");
      arc = ar_count;
      repeat (20) tick();
      check("poll_now_not_queued", 32'(ar_count), 32'(arc));

      // Table of read responses
      for (int i = 0; i < 7; i++) begin
         rsp_data = tbl[i].rdata;
         rsp_resp = tbl[i].rresp;
         pulse_poll();
         wait_read($sformatf("v%0d", i));
         check($sformatf("v%0d_sv", i), 32'(status_valid), 32'(tbl[i].sv));
         check($sformatf("v%0d_data", i), 32'(status_data), 32'(tbl[i].data));
         check($sformatf("v%0d_link", i), 32'(link_up), 32'(tbl[i].link));
         check($sformatf("v%0d_chg", i), 32'(link_changed), 32'(tbl[i].chg));
         check($sformatf("v%0d_berr", i), 32'(bus_error), 32'(tbl[i].berr));
      end
      rsp_resp = 2'b00;

      // Poll interval: AR rises 100 clocks after each R handshake; link alternates
      for (int k = 0; k < 3; k++) begin
         rsp_data = (k % 2 == 0) ? 16'h0000 : 16'h0004;
         n = 0;
         do begin tick(); n++; end while (!axil.arvalid && n < 300);
         check($sformatf("interval%0d", k), 32'(n), 32'd100);
         wait_read($sformatf("alt%0d", k));
         check($sformatf("alt%0d_chg", k), 32'(link_changed), 1);
         check($sformatf("alt%0d_sv", k), 32'(status_valid), 1);
      end

      // Enable cycling: no second init write
      enable = 1'b0;
      repeat (2) tick();
      check("disable_idle", 32'({busy, axil.arvalid}), 0);
      enable = 1'b1;
      tick();
      check("reenable_ar", 32'(axil.arvalid), 1);
      wait_read("reenable");
      check("no_second_init", 32'(wr_count), 1);

      // enable dropped mid-transaction: read completes, then idle
      pulse_poll();
      enable = 1'b0;
      wait_read("middrop");
      check("middrop_sv", 32'(status_valid), 1);
      arc = ar_count;
      repeat (120) tick();
      check("middrop_idle", 32'({busy, 32'(ar_count - arc)}), 0);
      enable = 1'b1;
      wait_read("resume");

      // Clear sticky bus error
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      check("clear_errors", 32'({timeout_error, bus_error}), 0);

      // Timeout at 16 clocks, read still completes
      rd_delay = 20;
      rsp_data = 16'h5A5A;
      pulse_poll();
      check("tmo_arvalid", 32'(axil.arvalid), 1);
      repeat (15) tick();
      check("tmo_not_yet", 32'(timeout_error), 0);
      tick();
      check("tmo_set", 32'(timeout_error), 1);
      check("tmo_rready_held", 32'(axil.rready), 1);
      wait_read("tmo");
      check("tmo_sv", 32'(status_valid), 1);
      check("tmo_data", 32'(status_data), 32'h5A5A);
      check("tmo_sticky", 32'(timeout_error), 1);
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      check("tmo_cleared", 32'(timeout_error), 0);

      // Bus error on rresp=SLVERR
      rd_delay = 2;
      rsp_resp = 2'b10;
      rsp_data = 16'hFFFF;
      pulse_poll();
      wait_read("slverr");
      check("slverr_berr", 32'(bus_error), 1);
      check("slverr_no_sv", 32'(status_valid), 0);
      check("slverr_data", 32'(status_data), 32'h5A5A);

      // Async reset in the middle of RD_R
      rsp_resp = 2'b00;
      rd_delay = 30;
      pulse_poll();
      repeat (3) tick();
      check("pre_rst_rready", 32'(axil.rready), 1);
      reset_n = 1'b0;
      #1;
      check("async_rst_outputs",
            32'({link_up, link_changed, status_valid, busy, timeout_error, bus_error}), 0);
      check("async_rst_data", 32'(status_data), 0);
      check("async_rst_rready", 32'(axil.rready), 0);
      tick();
      reset_n = 1'b1;
      rd_delay = 2;
      wait_read("after_rst");
      check("init_after_rst", 32'(wr_count), 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
